mem_stage: RTL and testbench

Memory-access stage of the five-stage CPU pipeline, sitting directly downstream of the EX/MEM pipeline register. It consumes the EX/MEM register outputs, performs the data-memory load/store over a req/ack handshake, resolves branch/jump redirection, and registers results into the MEM/WB boundary. While an access is outstanding it stalls the upstream pipeline.

---
 rtl/dmem_if.sv | 11 +
 rtl/mem_stage.sv | 107 ++++++++++
 tb/tb_mem_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: data-memory req/ack bus between the memory stage and data memory.
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage with req/ack data access, branch redirect and MEM/WB register.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] NewPC,
  input  logic [31:0] NewPC_Jump,
  input  logic        Zero,
  input  logic        Overflow,
  input  logic [31:0] ALUout,
  input  logic [31:0] busB,
  input  logic [4:0]  Rw,
  input  logic        MemWr,
  input  logic        Branch,
  input  logic        MemtoReg,
  input  logic        RegWr,
  input  logic        Jump,
  dmem_if.master      dmem,
  output logic        stall,
  output logic        pc_sel,
  output logic [31:0] pc_target,
  output logic [31:0] Dout_out,
  output logic [31:0] ALUout_out,
  output logic [4:0]  Rw_out,
  output logic        MemtoReg_out,
  output logic        RegWr_out,
  output logic        Overflow_out,
  output logic        misalign_err,
  output logic        bus_err
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] hold;
  logic        timed_out;
  logic        mem_op;
  logic        start;
  logic        cap;
  always_comb begin
    mem_op    = MemWr | MemtoReg;
    start     = (state == IDLE) & mem_op & ~|ALUout[1:0];
    cap       = ((state == IDLE) & ~start) | (state == DONE);
    stall     = start | (state == WAIT);
    pc_sel    = Jump | (Branch & Zero);
    pc_target = Jump ? NewPC_Jump : (pc_sel ? NewPC : 32'd0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      hold         <= '0;
      timed_out    <= 1'b0;
      dmem.req     <= 1'b0;
      dmem.we      <= 1'b0;
      dmem.addr    <= '0;
      dmem.wdata   <= '0;
      Dout_out     <= '0;
      ALUout_out   <= '0;
      Rw_out       <= '0;
      MemtoReg_out <= 1'b0;
      RegWr_out    <= 1'b0;
      Overflow_out <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dmem.req   <= 1'b1;
          dmem.we    <= MemWr;
          dmem.addr  <= ALUout;
          dmem.wdata <= busB;
          cnt        <= '0;
          timed_out  <= 1'b0;
          state      <= WAIT;
        end else misalign_err <= mem_op;
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (dmem.ack) begin
            hold     <= dmem.rdata;
            dmem.req <= 1'b0;
            state    <= DONE;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            hold      <= '0;
            timed_out <= 1'b1;
            dmem.req  <= 1'b0;
            bus_err   <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
      // in IDLE a memory op reaching here is misaligned and must not write back
      if (cap) begin
        ALUout_out   <= ALUout;
        Rw_out       <= Rw;
        MemtoReg_out <= MemtoReg;
        Overflow_out <= Overflow;
        Dout_out     <= (state == DONE) ? hold : 32'd0;
        RegWr_out    <= RegWr & ~((state == DONE) ? timed_out : mem_op);
      end
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage.
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] NewPC, NewPC_Jump, ALUout, busB;
  logic        Zero, Overflow, MemWr, Branch, MemtoReg, RegWr, Jump;
  logic [4:0]  Rw;
  logic        stall, pc_sel, MemtoReg_out, RegWr_out, Overflow_out, misalign_err, bus_err;
  logic [31:0] pc_target, Dout_out, ALUout_out;
  logic [4:0]  Rw_out;
  int          n_tests = 0;
  int          n_fail = 0;
  dmem_if dmem ();
  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .NewPC(NewPC), .NewPC_Jump(NewPC_Jump), .Zero(Zero),
    .Overflow(Overflow), .ALUout(ALUout), .busB(busB), .Rw(Rw), .MemWr(MemWr),
    .Branch(Branch), .MemtoReg(MemtoReg), .RegWr(RegWr), .Jump(Jump), .dmem(dmem.master),
    .stall(stall), .pc_sel(pc_sel), .pc_target(pc_target), .Dout_out(Dout_out),
    .ALUout_out(ALUout_out), .Rw_out(Rw_out), .MemtoReg_out(MemtoReg_out),
    .RegWr_out(RegWr_out), .Overflow_out(Overflow_out), .misalign_err(misalign_err),
    .bus_err(bus_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic op(input logic wr, input logic ld, input logic rw_en, input logic [4:0] rd,
                    input logic [31:0] addr, input logic [31:0] data);
    MemWr = wr; MemtoReg = ld; RegWr = rw_en; Rw = rd; ALUout = addr; busB = data;
    #1;
  endtask
  initial begin
    rst = 1'b1; NewPC = '0; NewPC_Jump = '0; Zero = 0; Overflow = 0; Branch = 0; Jump = 0;
    dmem.ack = 1'b0; dmem.rdata = '0;
    op(0, 0, 0, 0, 0, 0);
    tick; tick;
    rst = 1'b0;
    check("rst_req", dmem.req, 0);
    check("rst_dout", Dout_out, 0);
    check("rst_regwr", RegWr_out, 0);
    check("rst_errs", {misalign_err, bus_err}, 0);
    check("rst_stall", stall, 0);
    // ALU op
    Overflow = 1;
    op(0, 0, 1, 5, 32'h1234, 0);
    check("alu_stall", stall, 0);
    tick;
    check("alu_aluout", ALUout_out, 32'h1234);
    check("alu_rw", Rw_out, 5);
    check("alu_regwr", RegWr_out, 1);
    check("alu_dout", Dout_out, 0);
    check("alu_ovf", Overflow_out, 1);
    Overflow = 0;
    // load, ack in second WAIT cycle
    op(0, 1, 1, 7, 32'h40, 0);
    check("ld_stall_idle", stall, 1);
    tick;
    check("ld_req", dmem.req, 1);
    check("ld_we", dmem.we, 0);
    check("ld_addr", dmem.addr, 32'h40);
    check("ld_stall_w1", stall, 1);
    tick;
    dmem.ack = 1'b1; dmem.rdata = 32'hDEADBEEF;
    #1;
    check("ld_stall_w2", stall, 1);
    tick;
    dmem.ack = 1'b0;
    check("ld_req_fall", dmem.req, 0);
    check("ld_stall_done", stall, 0);
    tick;
    op(0, 0, 0, 0, 0, 0);
    check("ld_dout", Dout_out, 32'hDEADBEEF);
    check("ld_memtoreg", MemtoReg_out, 1);
    check("ld_regwr", RegWr_out, 1);
    check("ld_rw", Rw_out, 7);
    // store, immediate ack
    op(1, 0, 1, 9, 32'h80, 32'hCAFE0001);
    check("st_stall_idle", stall, 1);
    tick;
    check("st_we", dmem.we, 1);
    check("st_wdata", dmem.wdata, 32'hCAFE0001);
    check("st_addr", dmem.addr, 32'h80);
    dmem.ack = 1'b1;
    #1;
    check("st_stall_w1", stall, 1);
    tick;
    dmem.ack = 1'b0;
    check("st_stall_done", stall, 0);
    check("st_req_fall", dmem.req, 0);
    tick;
    op(0, 0, 0, 0, 0, 0);
    check("st_regwr", RegWr_out, 1);
    check("st_rw", Rw_out, 9);
    check("st_memtoreg", MemtoReg_out, 0);
    // misaligned load
    op(0, 1, 1, 3, 32'h42, 0);
    check("mis_stall", stall, 0);
    tick;
    op(0, 0, 0, 0, 0, 0);
    check("mis_err", misalign_err, 1);
    check("mis_req", dmem.req, 0);
    check("mis_regwr", RegWr_out, 0);
    check("mis_rw", Rw_out, 3);
    tick;
    check("mis_err_pulse", misalign_err, 0);
    // load that times out
    op(0, 1, 1, 4, 32'h44, 0);
    for (int i = 0; i < 4; i++) begin
      tick;
      check($sformatf("to_req_%0d", i), dmem.req, 1);
      check($sformatf("to_berr_%0d", i), bus_err, 0);
    end
    tick;
    check("to_req_fall", dmem.req, 0);
    check("to_berr", bus_err, 1);
    check("to_stall_done", stall, 0);
    dmem.ack = 1'b1; dmem.rdata = 32'h55;
    tick;
    op(0, 0, 0, 0, 0, 0);
    check("to_berr_pulse", bus_err, 0);
    check("to_regwr", RegWr_out, 0);
    check("to_dout", Dout_out, 0);
    check("to_rw", Rw_out, 4);
    tick;
    dmem.ack = 1'b0;
    check("stray_req", dmem.req, 0);
    check("stray_dout", Dout_out, 0);
    // redirect
    NewPC = 32'h100; NewPC_Jump = 32'h400; Branch = 1; Zero = 1; Jump = 1;
    #1;
    check("jmp_sel", pc_sel, 1);
    check("jmp_tgt", pc_target, 32'h400);
    Jump = 0;
    #1;
    check("br_sel", pc_sel, 1);
    check("br_tgt", pc_target, 32'h100);
    Zero = 0;
    #1;
    check("nbr_sel", pc_sel, 0);
    check("nbr_tgt", pc_target, 0);
    Branch = 0; Zero = 1;
    #1;
    check("nob_sel", pc_sel, 0);
    // reset during WAIT
    op(0, 1, 1, 6, 32'h48, 0);
    tick;
    check("rw_req", dmem.req, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    op(0, 0, 0, 0, 0, 0);
    check("rw_req_clr", dmem.req, 0);
    check("rw_stall", stall, 0);
    dmem.ack = 1'b1; dmem.rdata = 32'h77;
    tick;
    dmem.ack = 1'b0;
    check("rw_late_ack", dmem.req, 0);
    check("rw_dout", Dout_out, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
